alu_pipe: RTL

Handshaked, pipelined ALU unit that accepts operation requests on a valid/ready request port and returns results with flags on a valid/ready response port. It is the responder side of the operand/opcode interface: upstream initiators stop driving raw ALU inputs and holding them for a fixed delay. Instead they issue tagged requests, and alu_pipe buffers completed results until they are consumed. It sits between a command sequencer and any result consumer (register file, checker).

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_pipe_fifo.sv | 70 +++++++
 rtl/alu_pipe.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and response-record field widths.
// Used by alu_pipe, by the command sequencer that issues requests, and by the result checker.
// Pure declarations, no logic.
package alu_pkg;

  localparam int OPC_W  = 3;  // opcode field width
  localparam int TAG_W  = 2;  // initiator tag width
  localparam int FLAG_W = 2;  // carry + zero
  localparam int CNT_W  = 8;  // completed-operation counter width

  localparam logic [OPC_W-1:0] OP_ADD = 3'b000;
  localparam logic [OPC_W-1:0] OP_SUB = 3'b001;
  localparam logic [OPC_W-1:0] OP_AND = 3'b010;
  localparam logic [OPC_W-1:0] OP_OR  = 3'b011;
  localparam logic [OPC_W-1:0] OP_XOR = 3'b100;
  localparam logic [OPC_W-1:0] OP_NOT = 3'b101;
  localparam logic [OPC_W-1:0] OP_SHL = 3'b110;
  localparam logic [OPC_W-1:0] OP_SHR = 3'b111;

endpackage

// File: rtl/alu_pipe_fifo.sv
// Synchronous FIFO with wrap-bit pointers; writes become readable one cycle after the write edge.
// Latency: push at edge N, visible on !empty after edge N+1; no bypass.
// Backpressure: push ignored when full, pop ignored when empty; count reflects all written entries.
module alu_pipe_fifo #(
  parameter int WIDTH_DATA = 8,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [WIDTH_DATA-1:0]   push_data,
  input  logic                    pop,
  output logic [WIDTH_DATA-1:0]   pop_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  // Copy of wr_ptr delayed one cycle: the read side only sees completed writes.
  logic [AW:0]           vis_ptr_q, vis_ptr_d;
  logic [WIDTH_DATA-1:0] mem_q [DEPTH];
  logic [WIDTH_DATA-1:0] mem_d [DEPTH];
  logic                  push_en;
  logic                  pop_en;

  // Status flags: full/empty differ only in the wrap bit; count covers every written entry.
  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty    = (vis_ptr_q == rd_ptr_q);
    pop_data = mem_q[rd_ptr_q[AW-1:0]];
    push_en  = push && !full;
    pop_en   = pop && !empty;
  end

  // Next-state for pointers and storage.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    vis_ptr_d = wr_ptr_q;
    mem_d     = mem_q;
    if (push_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // State registers; storage is cleared so the read port shows zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      vis_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      vis_ptr_q <= vis_ptr_d;
      mem_q     <= mem_d;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked two-stage ALU: S1 registers the request, S2 computes and writes a result FIFO.
// Latency: accept at edge N, FIFO write at N+1, rsp_valid after N+2 when the FIFO was empty.
// Backpressure: credit-based req_ready (fifo_count + s1_valid < DEPTH) so S2 never stalls.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OPC_W-1:0]  req_opcode,
  input  logic [WIDTH-1:0]  req_operand_1,
  input  logic [WIDTH-1:0]  req_operand_2,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [CNT_W-1:0]  op_count
);

  localparam int CW    = $clog2(DEPTH);
  localparam int REC_W = WIDTH + FLAG_W + TAG_W;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             carry;
    logic             zero;
    logic [WIDTH-1:0] result;
  } rsp_rec_t;

  logic              s1_valid_q, s1_valid_d;
  logic [OPC_W-1:0]  s1_opcode_q, s1_opcode_d;
  logic [WIDTH-1:0]  s1_a_q, s1_a_d;
  logic [WIDTH-1:0]  s1_b_q, s1_b_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  logic              accept;
  logic [CW+1:0]     occupancy;
  logic [WIDTH:0]    sum_ext;
  logic [WIDTH:0]    diff_ext;
  rsp_rec_t          s2_rec;
  rsp_rec_t          head_rec;
  logic [REC_W-1:0]  fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW:0]       fifo_count;
  logic              fifo_push;
  logic              fifo_pop;

  // Credit check: every accepted-but-unpopped request owns a FIFO slot, so S2 can always write.
  always_comb begin
    occupancy = {1'b0, fifo_count} + {{(CW+1){1'b0}}, s1_valid_q};
    req_ready = (occupancy < (CW+2)'(DEPTH));
    accept    = req_valid && req_ready;
  end

  // S1 capture: load on accept, valid drops when nothing is accepted.
  always_comb begin
    s1_valid_d  = accept;
    s1_opcode_d = s1_opcode_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_tag_d    = s1_tag_q;
    if (accept) begin
      s1_opcode_d = req_opcode;
      s1_a_d      = req_operand_1;
      s1_b_d      = req_operand_2;
      s1_tag_d    = req_tag;
    end
  end

  // S2 compute: result truncated to WIDTH, carry per opcode, zero on the truncated result.
  always_comb begin
    sum_ext       = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    diff_ext      = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    s2_rec        = '0;
    s2_rec.tag    = s1_tag_q;
    case (s1_opcode_q)
      OP_ADD: begin
        s2_rec.result = sum_ext[WIDTH-1:0];
        s2_rec.carry  = sum_ext[WIDTH];
      end
      OP_SUB: begin
        s2_rec.result = diff_ext[WIDTH-1:0];
        s2_rec.carry  = diff_ext[WIDTH];  // borrow out == (A < B) unsigned
      end
      OP_AND: s2_rec.result = s1_a_q & s1_b_q;
      OP_OR:  s2_rec.result = s1_a_q | s1_b_q;
      OP_XOR: s2_rec.result = s1_a_q ^ s1_b_q;
      OP_NOT: s2_rec.result = ~s1_a_q;
      OP_SHL: begin
        s2_rec.result = {s1_a_q[WIDTH-2:0], 1'b0};
        s2_rec.carry  = s1_a_q[WIDTH-1];
      end
      default: begin  // OP_SHR, logical
        s2_rec.result = {1'b0, s1_a_q[WIDTH-1:1]};
        s2_rec.carry  = s1_a_q[0];
      end
    endcase
    s2_rec.zero = ~|s2_rec.result;
  end

  // FIFO push/pop and the completed-operation counter (counts writes, not pops).
  always_comb begin
    fifo_push  = s1_valid_q && !fifo_full;
    fifo_pop   = rsp_valid && rsp_ready;
    op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, fifo_push};
  end

  // Pipeline registers with synchronous reset; reset discards S1 and clears the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_opcode_q <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_tag_q    <= '0;
      op_count_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_opcode_q <= s1_opcode_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_tag_q    <= s1_tag_d;
      op_count_q  <= op_count_d;
    end
  end

  alu_pipe_fifo #(
    .WIDTH_DATA (REC_W),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (s2_rec),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Response port driven straight from the FIFO head.
  always_comb begin
    head_rec   = rsp_rec_t'(fifo_rdata);
    rsp_valid  = !fifo_empty;
    rsp_result = head_rec.result;
    rsp_carry  = head_rec.carry;
    rsp_zero   = head_rec.zero;
    rsp_tag    = head_rec.tag;
    op_count   = op_count_q;
  end

endmodule
